// File: rtl/split_radio_pipe.sv
// Registered differential receive splitter: complementarity check on the input
// pair, then per-channel programmable-delay taps in broadcast or round-robin mode.
module split_radio_pipe #(
  parameter int unsigned  WIDTH    = 1,
  parameter int unsigned  DEPTH    = 3,
  parameter int unsigned  CHANNELS = 2,
  parameter int unsigned  ERR_W    = 8,
  localparam int unsigned DW       = $clog2(DEPTH + 1)
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [WIDTH-1:0]          Receive_P,
  input  logic [WIDTH-1:0]          Receive_N,
  input  logic                      Receive_Valid,
  input  logic                      Mode,
  input  logic [CHANNELS*DW-1:0]    Delay_Sel,
  input  logic                      Fault_Clear,
  output logic [CHANNELS*WIDTH-1:0] Out_Data,
  output logic [CHANNELS-1:0]       Out_Valid,
  output logic                      Fault,
  output logic [ERR_W-1:0]          Fault_Count
);
  localparam int unsigned PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                in_v;
  logic [WIDTH-1:0]    in_p;
  logic [WIDTH-1:0]    in_n;
  logic                good;
  logic                bad;
  logic [PW-1:0]       ptr;
  logic [CHANNELS-1:0] wr;

  logic                pipe_v [CHANNELS][DEPTH];
  logic [WIDTH-1:0]    pipe_d [CHANNELS][DEPTH];
  logic [TW-1:0]       tap    [CHANNELS];
  logic                tap_v  [CHANNELS];
  logic [WIDTH-1:0]    tap_d  [CHANNELS];

  // Delay field to 0-based stage index: 0 acts as 1, anything above DEPTH as DEPTH.
  function automatic logic [TW-1:0] tap_index(input logic [DW-1:0] f);
    int unsigned d;
    d = 32'(f);
    if (d == 0) d = 1;
    else if (d > DEPTH) d = DEPTH;
    return TW'(d - 1);
  endfunction

  always_comb begin
    good = in_v && (in_p == ~in_n);
    bad  = in_v && (in_p != ~in_n);
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      wr[c]    = good && (!Mode || (ptr == PW'(c)));
      tap[c]   = tap_index(Delay_Sel[c*DW +: DW]);
      tap_v[c] = pipe_v[c][tap[c]];
      tap_d[c] = pipe_d[c][tap[c]];
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      in_v <= 1'b0;
      in_p <= '0;
      in_n <= '0;
    end else begin
      in_v <= Receive_Valid;
      in_p <= Receive_P;
      in_n <= Receive_N;
    end
  end

  // Pointer only moves on good samples in round-robin mode; broadcast parks it at 0.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr <= '0;
    end else if (!Mode) begin
      ptr <= '0;
    end else if (good) begin
      ptr <= (ptr == PW'(CHANNELS - 1)) ? '0 : ptr + 1'b1;
    end
  end

  // A faulted sample outranks a simultaneous clear and restarts the count at 1.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Fault       <= 1'b0;
      Fault_Count <= '0;
    end else if (bad) begin
      Fault       <= 1'b1;
      Fault_Count <= Fault_Clear ? ERR_W'(1)
                   : ((Fault_Count == '1) ? Fault_Count : Fault_Count + 1'b1);
    end else if (Fault_Clear) begin
      Fault       <= 1'b0;
      Fault_Count <= '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
          pipe_v[c][s] <= 1'b0;
          pipe_d[c][s] <= '0;
        end
      end
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        pipe_v[c][0] <= wr[c];
        pipe_d[c][0] <= in_p;
        for (int unsigned s = 1; s < DEPTH; s++) begin
          pipe_v[c][s] <= pipe_v[c][s-1];
          pipe_d[c][s] <= pipe_d[c][s-1];
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Out_Valid <= '0;
      Out_Data  <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        Out_Valid[c]               <= tap_v[c];
        Out_Data[c*WIDTH +: WIDTH] <= tap_v[c] ? tap_d[c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_split_radio_pipe.sv
// Bench for split_radio_pipe: directed scenarios plus a randomized stream
// checked against an event-list model of expected channel outputs.
module tb_split_radio_pipe;
  localparam int unsigned WIDTH    = 1;
  localparam int unsigned DEPTH    = 3;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned ERR_W    = 2;
  localparam int unsigned DW       = 2;
  localparam int          MAXCNT   = 3;
  localparam int          MAXC     = 8192;

  logic                      Clock = 1'b0;
  logic                      Reset_n = 1'b1;
  logic [WIDTH-1:0]          Receive_P = '0;
  logic [WIDTH-1:0]          Receive_N = '0;
  logic                      Receive_Valid = 1'b0;
  logic                      Mode = 1'b0;
  logic [CHANNELS*DW-1:0]    Delay_Sel = '0;
  logic                      Fault_Clear = 1'b0;
  logic [CHANNELS*WIDTH-1:0] Out_Data;
  logic [CHANNELS-1:0]       Out_Valid;
  logic                      Fault;
  logic [ERR_W-1:0]          Fault_Count;

  split_radio_pipe #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .ERR_W(ERR_W)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Receive_P(Receive_P), .Receive_N(Receive_N), .Receive_Valid(Receive_Valid),
    .Mode(Mode), .Delay_Sel(Delay_Sel), .Fault_Clear(Fault_Clear),
    .Out_Data(Out_Data), .Out_Valid(Out_Valid),
    .Fault(Fault), .Fault_Count(Fault_Count)
  );

  initial forever #5 Clock = ~Clock;

  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  bit               ev [CHANNELS][MAXC];
  logic [WIDTH-1:0] ed [CHANNELS][MAXC];
  int               rr = 0;
  bit               m_fault = 0;
  int               m_cnt = 0;
  bit               pend = 0;

  function automatic int eff_delay(input int f);
    return (f == 0) ? 1 : ((f > DEPTH) ? DEPTH : f);
  endfunction

  task automatic drive(input bit v, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n);
    Receive_Valid = v;
    Receive_P     = p;
    Receive_N     = n;
  endtask

  task automatic forget_in_flight();
    for (int c = 0; c < CHANNELS; c++)
      for (int t = cyc + 1; t < MAXC; t++) ev[c][t] = 1'b0;
  endtask

  // One clock edge; the model books each good sample at edge + 1 + delay.
  task automatic tick();
    bit good;
    int t;
    @(posedge Clock);
    cyc++;
    if (!Reset_n) begin
      pend = 0; rr = 0; m_fault = 0; m_cnt = 0;
    end else begin
      if (pend) begin
        m_fault = 1;
        m_cnt   = Fault_Clear ? 1 : ((m_cnt < MAXCNT) ? m_cnt + 1 : MAXCNT);
      end else if (Fault_Clear) begin
        m_fault = 0;
        m_cnt   = 0;
      end
      good = Receive_Valid && (Receive_P === ~Receive_N);
      pend = Receive_Valid && !good;
      if (good) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (!Mode || rr == c) begin
            t = cyc + 1 + eff_delay(int'(Delay_Sel[c*DW +: DW]));
            if (t < MAXC) begin
              ev[c][t] = 1'b1;
              ed[c][t] = Receive_P;
            end
          end
        end
        if (Mode) rr = (rr + 1) % CHANNELS;
      end
      if (!Mode) rr = 0;
    end
    #2;
  endtask

  task automatic test_reset();
    Fault_Clear = 1'b0; Mode = 1'b0; Delay_Sel = {2'd3, 2'd1};
    drive(1'b0, 1'b0, 1'b0);
    #1 Reset_n = 1'b0;
    forget_in_flight();
    #1;
    n_checks++;
    if ({Out_Valid, Out_Data, Fault, Fault_Count} !== '0) begin
      n_fail++;
      $display("FAIL reset_async got=%b want=0", {Out_Valid, Out_Data, Fault, Fault_Count});
    end
    tick(); tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({Out_Valid, Out_Data, Fault, Fault_Count} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%b want=0", i, {Out_Valid, Out_Data, Fault, Fault_Count});
      end
    end
  endtask

  task automatic test_broadcast();
    logic [1:0] ov [6];
    logic [1:0] od [6];
    logic [1:0] xv [6];
    logic [1:0] xd [6];
    xv = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
    xd = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    Mode = 1'b0; Delay_Sel = {2'd3, 2'd1};
    for (int r = 0; r < 6; r++) begin
      if (r == 0) drive(1'b1, 1'b1, 1'b0);
      else if (r == 1) drive(1'b1, 1'b0, 1'b1);
      else drive(1'b0, 1'b0, 1'b0);
      tick();
      ov[r] = Out_Valid;
      od[r] = Out_Data;
    end
    for (int r = 0; r < 6; r++) begin
      n_checks++;
      if (ov[r] !== xv[r]) begin
        n_fail++;
        $display("FAIL bcast_valid edge=%0d got=%b want=%b", r, ov[r], xv[r]);
      end
      n_checks++;
      if (od[r] !== xd[r]) begin
        n_fail++;
        $display("FAIL bcast_data edge=%0d got=%b want=%b", r, od[r], xd[r]);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] ov [7];
    logic [1:0] od [7];
    logic [1:0] xv [7];
    logic [1:0] xd [7];
    logic [3:0] bits;
    Mode = 1'b1; Delay_Sel = {2'd1, 2'd1};
    tick();
    bits = 4'b1101;
    for (int r = 0; r < 7; r++) begin
      if (r < 4) drive(1'b1, bits[r], ~bits[r]);
      else drive(1'b0, 1'b0, 1'b0);
      tick();
      ov[r] = Out_Valid;
      od[r] = Out_Data;
    end
    xv = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    xd = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00};
    for (int r = 0; r < 7; r++) begin
      n_checks++;
      if (ov[r] !== xv[r] || od[r] !== xd[r]) begin
        n_fail++;
        $display("FAIL rr_plain edge=%0d got v=%b d=%b want v=%b d=%b", r, ov[r], od[r], xv[r], xd[r]);
      end
    end
    repeat (2) tick();
    for (int r = 0; r < 7; r++) begin
      case (r)
        0: drive(1'b1, 1'b1, 1'b0);
        1: drive(1'b1, 1'b1, 1'b1);
        2: drive(1'b1, 1'b0, 1'b1);
        3: drive(1'b1, 1'b1, 1'b0);
        default: drive(1'b0, 1'b0, 1'b0);
      endcase
      tick();
      ov[r] = Out_Valid;
      od[r] = Out_Data;
    end
    xv = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
    xd = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    for (int r = 0; r < 7; r++) begin
      n_checks++;
      if (ov[r] !== xv[r] || od[r] !== xd[r]) begin
        n_fail++;
        $display("FAIL rr_fault_skip edge=%0d got v=%b d=%b want v=%b d=%b", r, ov[r], od[r], xv[r], xd[r]);
      end
    end
    n_checks++;
    if (Fault !== 1'b1 || Fault_Count !== 2'd1) begin
      n_fail++;
      $display("FAIL rr_fault_flag got f=%b n=%0d want f=1 n=1", Fault, Fault_Count);
    end
    repeat (2) tick();
    Mode = 1'b0;
    tick();
  endtask

  task automatic test_fault();
    Fault_Clear = 1'b1;
    tick();
    Fault_Clear = 1'b0;
    n_checks++;
    if (Fault !== 1'b0 || Fault_Count !== 2'd0) begin
      n_fail++;
      $display("FAIL fault_clear_pre got f=%b n=%0d want f=0 n=0", Fault, Fault_Count);
    end
    Delay_Sel = {2'd1, 2'd1};
    for (int r = 0; r < 5; r++) begin
      if (r == 0) drive(1'b1, 1'b1, 1'b1);
      else drive(1'b0, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (Fault !== (r >= 1) || Fault_Count !== ((r >= 1) ? 2'd1 : 2'd0) || Out_Valid !== 2'b00) begin
        n_fail++;
        $display("FAIL fault_single edge=%0d got f=%b n=%0d v=%b want f=%b n=%0d v=00",
                 r, Fault, Fault_Count, Out_Valid, (r >= 1), (r >= 1));
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(1'b1, 1'b0, 1'b0);
      else drive(1'b0, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (Fault_Count !== 2'((1 + i > MAXCNT) ? MAXCNT : 1 + i) || Out_Valid !== 2'b00) begin
        n_fail++;
        $display("FAIL fault_saturate step=%0d got n=%0d v=%b want n=%0d v=00",
                 i, Fault_Count, Out_Valid, (1 + i > MAXCNT) ? MAXCNT : 1 + i);
      end
    end
  endtask

  task automatic test_clear_collide();
    Fault_Clear = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    Fault_Clear = 1'b0;
    n_checks++;
    if (Fault !== 1'b1 || Fault_Count !== 2'd1) begin
      n_fail++;
      $display("FAIL clear_vs_fault got f=%b n=%0d want f=1 n=1", Fault, Fault_Count);
    end
    Fault_Clear = 1'b1;
    tick();
    Fault_Clear = 1'b0;
    n_checks++;
    if (Fault !== 1'b0 || Fault_Count !== 2'd0) begin
      n_fail++;
      $display("FAIL clear_alone got f=%b n=%0d want f=0 n=0", Fault, Fault_Count);
    end
  endtask

  task automatic test_clamp_reset();
    logic [1:0] ov [6];
    logic [1:0] xv [6];
    // A field of 7 truncates to the 2-bit field maximum, i.e. full depth.
    Delay_Sel = {2'(3'd7), 2'd0};
    tick();
    for (int r = 0; r < 6; r++) begin
      if (r == 0) drive(1'b1, 1'b1, 1'b0);
      else drive(1'b0, 1'b0, 1'b0);
      tick();
      ov[r] = Out_Valid;
      n_checks++;
      if (Out_Data !== ov[r]) begin
        n_fail++;
        $display("FAIL clamp_data edge=%0d got=%b want=%b", r, Out_Data, ov[r]);
      end
    end
    xv = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    for (int r = 0; r < 6; r++) begin
      n_checks++;
      if (ov[r] !== xv[r]) begin
        n_fail++;
        $display("FAIL clamp_valid edge=%0d got=%b want=%b", r, ov[r], xv[r]);
      end
    end
    Delay_Sel = {2'd3, 2'd3};
    repeat (2) tick();
    for (int r = 0; r < 5; r++) begin
      if (r < 3) drive(1'b1, 1'(r != 1), 1'(r == 1));
      else drive(1'b0, 1'b0, 1'b0);
      tick();
    end
    n_checks++;
    if (Out_Valid !== 2'b11) begin
      n_fail++;
      $display("FAIL midreset_pre got=%b want=11", Out_Valid);
    end
    Reset_n = 1'b0;
    forget_in_flight();
    #1;
    n_checks++;
    if (Out_Valid !== 2'b00 || Out_Data !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_drop got v=%b d=%b want v=00 d=00", Out_Valid, Out_Data);
    end
    tick(); tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (Out_Valid !== 2'b00) begin
        n_fail++;
        $display("FAIL midreset_stale cyc=%0d got=%b want=00", i, Out_Valid);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [CHANNELS-1:0]       xv;
    logic [CHANNELS*WIDTH-1:0] xd;
    logic [WIDTH-1:0]          p;
    for (int seg = 0; seg < 8; seg++) begin
      Mode      = 1'($urandom_range(0, 1));
      Delay_Sel = 4'($urandom_range(0, 15));
      for (int i = 0; i < 66; i++) begin
        if (i < 60) begin
          p = 1'($urandom_range(0, 1));
          drive(1'($urandom_range(0, 3) != 0), p, ($urandom_range(0, 7) == 0) ? p : ~p);
          Fault_Clear = ($urandom_range(0, 15) == 0);
        end else begin
          drive(1'b0, 1'b0, 1'b0);
          Fault_Clear = 1'b0;
        end
        tick();
        for (int c = 0; c < CHANNELS; c++) begin
          xv[c] = ev[c][cyc];
          xd[c*WIDTH +: WIDTH] = ev[c][cyc] ? ed[c][cyc] : '0;
        end
        n_checks++;
        if (Out_Valid !== xv || Out_Data !== xd) begin
          n_fail++;
          $display("FAIL rand_out seg=%0d i=%0d got v=%b d=%b want v=%b d=%b", seg, i, Out_Valid, Out_Data, xv, xd);
        end
        n_checks++;
        if (Fault !== m_fault || Fault_Count !== 2'(m_cnt)) begin
          n_fail++;
          $display("FAIL rand_fault seg=%0d i=%0d got f=%b n=%0d want f=%b n=%0d", seg, i, Fault, Fault_Count, m_fault, m_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_broadcast();
    test_round_robin();
    test_fault();
    test_clear_collide();
    test_clamp_reset();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
